// File: rtl/multicycle_control_sequencer_if.sv
// multicycle_control_sequencer_if: command inputs and datapath control outputs of the sequencer
interface multicycle_control_sequencer_if #(parameter int COUNT_W = 16);
    logic start, step, zero;
    logic [10:0] opcode;
    logic pcWrite, pcSrc, irWrite, regWrite, memRead, memWrite, aluSrc, memToReg, reg2Loc;
    logic [1:0] aluOp;
    logic [2:0] state;
    logic busy, halted, illegal;
    logic [COUNT_W-1:0] instrCount;
    modport master(output start, step, opcode, zero,
                   input pcWrite, pcSrc, irWrite, regWrite, memRead, memWrite, aluSrc, memToReg,
                   reg2Loc, aluOp, state, busy, halted, illegal, instrCount);
    modport slave(input start, step, opcode, zero,
                  output pcWrite, pcSrc, irWrite, regWrite, memRead, memWrite, aluSrc, memToReg,
                  reg2Loc, aluOp, state, busy, halted, illegal, instrCount);
endinterface

// File: rtl/multicycle_control_sequencer.sv
// multicycle_control_sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller for a small ARM-like datapath
module multicycle_control_sequencer #(
    parameter logic [15:0] INSTR_LIMIT = 16'd0,
    parameter int COUNT_W = 16
) (
    input logic clock,
    input logic resetN,
    multicycle_control_sequencer_if.slave ctl
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
        S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_HALT = 3'd6
    } state_t;
    typedef enum logic [2:0] {C_R, C_LD, C_ST, C_CBZ, C_B, C_ILL} cls_t;

    function automatic cls_t decode(input logic [10:0] op);
        return (op == 11'b10001011000 || op == 11'b11001011000 ||
                op == 11'b10001010000 || op == 11'b10101010000) ? C_R :
               op == 11'b11111000010 ? C_LD :
               op == 11'b11111000000 ? C_ST :
               op[10:3] == 8'b10110100 ? C_CBZ :
               op[10:5] == 6'b000101 ? C_B : C_ILL;
    endfunction

    state_t st, nxt, after;
    cls_t cls;
    logic [10:0] op_r;
    logic [COUNT_W-1:0] cnt, cnt_nxt;
    logic step_mode, done;
    logic pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, mem_to_reg;
    logic busy, halted, illegal;
    logic [1:0] alu_op;

    // The opcode is live only in DECODE; later states use the latched copy.
    always_comb begin
        cls = decode(st == S_DECODE ? ctl.opcode : op_r);
        cnt_nxt = cnt + COUNT_W'(1);
        done = (st == S_EXECUTE && (cls == C_CBZ || cls == C_B)) ||
               (st == S_MEMORY && cls == C_ST) || st == S_WRITEBACK;
        after = (INSTR_LIMIT != 16'd0 && cnt_nxt == COUNT_W'(INSTR_LIMIT)) ? S_HALT :
                step_mode ? S_IDLE : S_FETCH;
        nxt = S_IDLE;
        case (st)
            S_IDLE:      nxt = (ctl.start || ctl.step) ? S_FETCH : S_IDLE;
            S_FETCH:     nxt = S_DECODE;
            S_DECODE:    nxt = cls == C_ILL ? S_HALT : S_EXECUTE;
            S_EXECUTE:   nxt = cls == C_R ? S_WRITEBACK :
                               (cls == C_LD || cls == C_ST) ? S_MEMORY : after;
            S_MEMORY:    nxt = cls == C_LD ? S_WRITEBACK : after;
            S_WRITEBACK: nxt = after;
            S_HALT:      nxt = S_HALT;
            default:     nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            st <= S_IDLE;
            op_r <= '0;
            cnt <= '0;
            step_mode <= 1'b0;
            illegal <= 1'b0;
            pc_write <= 1'b0;
            ir_write <= 1'b0;
            reg_write <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            alu_src <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_op <= 2'b00;
            busy <= 1'b0;
            halted <= 1'b0;
        end else begin
            st <= nxt;
            if (st == S_IDLE) step_mode <= ctl.step && !ctl.start;
            if (st == S_DECODE) op_r <= ctl.opcode;
            if (st == S_DECODE && cls == C_ILL) illegal <= 1'b1;
            if (done) cnt <= cnt_nxt;
            ir_write <= nxt == S_FETCH;
            alu_src <= nxt == S_EXECUTE && (cls == C_LD || cls == C_ST);
            alu_op <= nxt != S_EXECUTE ? 2'b00 : cls == C_R ? 2'b10 : cls == C_CBZ ? 2'b01 : 2'b00;
            mem_read <= nxt == S_MEMORY && cls == C_LD;
            mem_write <= nxt == S_MEMORY && cls == C_ST;
            reg_write <= nxt == S_WRITEBACK;
            mem_to_reg <= nxt == S_WRITEBACK && cls == C_LD;
            pc_write <= (nxt == S_EXECUTE && (cls == C_CBZ || cls == C_B)) ||
                        (nxt == S_MEMORY && cls == C_ST) || nxt == S_WRITEBACK;
            busy <= nxt != S_IDLE && nxt != S_HALT;
            halted <= nxt == S_HALT;
        end
    end

    // pcSrc follows zero within the CBZ EXECUTE cycle, so it cannot be registered.
    assign ctl.pcSrc = st == S_EXECUTE && (cls == C_B || (cls == C_CBZ && ctl.zero));
    assign ctl.reg2Loc = st == S_DECODE && (cls == C_ST || cls == C_CBZ);
    assign ctl.pcWrite = pc_write;
    assign ctl.irWrite = ir_write;
    assign ctl.regWrite = reg_write;
    assign ctl.memRead = mem_read;
    assign ctl.memWrite = mem_write;
    assign ctl.aluSrc = alu_src;
    assign ctl.memToReg = mem_to_reg;
    assign ctl.aluOp = alu_op;
    assign ctl.state = st;
    assign ctl.busy = busy;
    assign ctl.halted = halted;
    assign ctl.illegal = illegal;
    assign ctl.instrCount = cnt;
endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// tb_multicycle_control_sequencer: vector table plus directed multi-cycle sequences
module tb_multicycle_control_sequencer;
    typedef struct packed {
        logic [2:0] st;
        logic [8:0] ctl;
        logic [1:0] aop;
        logic busy, halted, ill;
        logic [15:0] cnt;
    } out_t;
    typedef struct {
        logic start, step;
        logic [10:0] op;
        logic zero;
        out_t exp;
    } vec_t;

    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_ORR = 11'b10101010000,
        OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
        OP_CBZ = 11'b10110100101, OP_B = 11'b00010111111, OP_BAD = 11'b11111111111;
    localparam logic [8:0] PW = 9'h100, PS = 9'h080, IW = 9'h040, RW = 9'h020, MR = 9'h010,
        MW = 9'h008, AS = 9'h004, MTR = 9'h002, R2L = 9'h001, NC = 9'h000;

    logic clk = 1'b0, rst_n = 1'b0;
    int nvec = 0, nbad = 0;
    out_t o0, o1;
    vec_t tv[$];

    multicycle_control_sequencer_if i0();
    multicycle_control_sequencer_if i1();
    multicycle_control_sequencer u0(.clock(clk), .resetN(rst_n), .ctl(i0));
    multicycle_control_sequencer #(.INSTR_LIMIT(16'd3)) u1(.clock(clk), .resetN(rst_n), .ctl(i1));

    always #5 clk = ~clk;

    assign o0 = {i0.state, i0.pcWrite, i0.pcSrc, i0.irWrite, i0.regWrite, i0.memRead, i0.memWrite,
                 i0.aluSrc, i0.memToReg, i0.reg2Loc, i0.aluOp, i0.busy, i0.halted, i0.illegal, i0.instrCount};
    assign o1 = {i1.state, i1.pcWrite, i1.pcSrc, i1.irWrite, i1.regWrite, i1.memRead, i1.memWrite,
                 i1.aluSrc, i1.memToReg, i1.reg2Loc, i1.aluOp, i1.busy, i1.halted, i1.illegal, i1.instrCount};

    function automatic out_t ex(input logic [2:0] s, input logic [8:0] c, input logic [1:0] a,
                                input logic il, input logic [15:0] n);
        return {s, c, a, s != 3'd0 && s != 3'd6, s == 3'd6, il, n};
    endfunction

    function automatic vec_t v(input logic sa, input logic sp, input logic [10:0] op,
                               input logic z, input out_t e);
        return '{sa, sp, op, z, e};
    endfunction

    function automatic logic [8:0] lctl(input int p);
        return p == 1 ? IW : p == 3 ? AS : p == 4 ? MR : p == 5 ? (RW | MTR | PW) : NC;
    endfunction

    task automatic drive(input logic sa, input logic sp, input logic [10:0] op, input logic z);
        i0.start = sa; i0.step = sp; i0.opcode = op; i0.zero = z;
        i1.start = sa; i1.step = sp; i1.opcode = op; i1.zero = z;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input out_t a, input out_t e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chkv(input string nm, input int a, input int e);
        nvec++;
        if (a != e) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, OP_ADD, 1'b0);
        cyc();
        cyc();
        chk("reset_u0", o0, ex(3'd0, NC, 2'b00, 1'b0, 16'd0));
        chk("reset_u1", o1, ex(3'd0, NC, 2'b00, 1'b0, 16'd0));
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_hold", o0, ex(3'd0, NC, 2'b00, 1'b0, 16'd0));
    endtask

    initial begin
        int mw, mw_at, h_at;
        drive(1'b0, 1'b0, OP_ADD, 1'b0);
        // step ADD
        tv.push_back(v(1'b0, 1'b1, OP_ADD, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd0)));
        tv.push_back(v(1'b0, 1'b0, OP_ADD, 1'b0, ex(3'd2, NC, 2'b00, 1'b0, 16'd0)));
        tv.push_back(v(1'b0, 1'b0, OP_ADD, 1'b0, ex(3'd3, NC, 2'b10, 1'b0, 16'd0)));
        tv.push_back(v(1'b0, 1'b0, OP_ADD, 1'b0, ex(3'd5, RW | PW, 2'b00, 1'b0, 16'd0)));
        tv.push_back(v(1'b0, 1'b0, OP_ADD, 1'b0, ex(3'd0, NC, 2'b00, 1'b0, 16'd1)));
        // step CBZ taken, then not taken
        tv.push_back(v(1'b0, 1'b1, OP_CBZ, 1'b1, ex(3'd1, IW, 2'b00, 1'b0, 16'd1)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b1, ex(3'd2, R2L, 2'b00, 1'b0, 16'd1)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b1, ex(3'd3, PW | PS, 2'b01, 1'b0, 16'd1)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b1, ex(3'd0, NC, 2'b00, 1'b0, 16'd2)));
        tv.push_back(v(1'b0, 1'b1, OP_CBZ, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd2)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b0, ex(3'd2, R2L, 2'b00, 1'b0, 16'd2)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b0, ex(3'd3, PW, 2'b01, 1'b0, 16'd2)));
        tv.push_back(v(1'b0, 1'b0, OP_CBZ, 1'b0, ex(3'd0, NC, 2'b00, 1'b0, 16'd3)));
        // step B
        tv.push_back(v(1'b0, 1'b1, OP_B, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd3)));
        tv.push_back(v(1'b0, 1'b0, OP_B, 1'b0, ex(3'd2, NC, 2'b00, 1'b0, 16'd3)));
        tv.push_back(v(1'b0, 1'b0, OP_B, 1'b0, ex(3'd3, PW | PS, 2'b00, 1'b0, 16'd3)));
        tv.push_back(v(1'b0, 1'b0, OP_B, 1'b0, ex(3'd0, NC, 2'b00, 1'b0, 16'd4)));
        // step STUR with start/step pulsed while busy (ignored)
        tv.push_back(v(1'b0, 1'b1, OP_STUR, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd4)));
        tv.push_back(v(1'b1, 1'b0, OP_STUR, 1'b0, ex(3'd2, R2L, 2'b00, 1'b0, 16'd4)));
        tv.push_back(v(1'b1, 1'b1, OP_STUR, 1'b0, ex(3'd3, AS, 2'b00, 1'b0, 16'd4)));
        tv.push_back(v(1'b0, 1'b0, OP_STUR, 1'b0, ex(3'd4, MW | PW, 2'b00, 1'b0, 16'd4)));
        tv.push_back(v(1'b0, 1'b0, OP_STUR, 1'b0, ex(3'd0, NC, 2'b00, 1'b0, 16'd5)));
        // start+step together selects run mode: ORR then back to FETCH
        tv.push_back(v(1'b1, 1'b1, OP_ORR, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd5)));
        tv.push_back(v(1'b0, 1'b0, OP_ORR, 1'b0, ex(3'd2, NC, 2'b00, 1'b0, 16'd5)));
        tv.push_back(v(1'b0, 1'b0, OP_ORR, 1'b0, ex(3'd3, NC, 2'b10, 1'b0, 16'd5)));
        tv.push_back(v(1'b0, 1'b0, OP_ORR, 1'b0, ex(3'd5, RW | PW, 2'b00, 1'b0, 16'd5)));
        tv.push_back(v(1'b0, 1'b0, OP_ORR, 1'b0, ex(3'd1, IW, 2'b00, 1'b0, 16'd6)));

        do_reset();
        foreach (tv[i]) begin
            drive(tv[i].start, tv[i].step, tv[i].op, tv[i].zero);
            cyc();
            chk($sformatf("vec%0d", i), o0, tv[i].exp);
        end

        // LDUR in run mode: 5-cycle instructions back to back
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            drive(k == 1, 1'b0, OP_LDUR, 1'b0);
            cyc();
            chk($sformatf("ldur_c%0d", k), o0,
                ex(3'(((k - 1) % 5) + 1), lctl(((k - 1) % 5) + 1), 2'b00, 1'b0, 16'((k - 1) / 5)));
        end

        // instruction limit of 3 with STUR, then start ignored in HALT
        do_reset();
        mw = 0; mw_at = 0; h_at = 0;
        for (int k = 1; k <= 40; k++) begin
            drive(k == 1, 1'b0, OP_STUR, 1'b0);
            cyc();
            if (i1.memWrite) begin
                mw++;
                mw_at = k;
            end
            if (i1.halted) begin
                h_at = k;
                break;
            end
        end
        chkv("halt_cycle", h_at, 13);
        chkv("mw_count", mw, 3);
        chkv("mw_last", mw_at, 12);
        chk("halt_state", o1, ex(3'd6, NC, 2'b00, 1'b0, 16'd3));
        drive(1'b1, 1'b0, OP_STUR, 1'b0);
        cyc();
        drive(1'b0, 1'b1, OP_STUR, 1'b0);
        cyc();
        drive(1'b0, 1'b0, OP_STUR, 1'b0);
        cyc();
        chk("halt_sticky", o1, ex(3'd6, NC, 2'b00, 1'b0, 16'd3));

        // illegal opcode halts from DECODE with no strobes
        do_reset();
        drive(1'b0, 1'b1, OP_BAD, 1'b0);
        cyc();
        chk("ill_fetch", o0, ex(3'd1, IW, 2'b00, 1'b0, 16'd0));
        drive(1'b0, 1'b0, OP_BAD, 1'b0);
        cyc();
        chk("ill_decode", o0, ex(3'd2, NC, 2'b00, 1'b0, 16'd0));
        cyc();
        chk("ill_halt", o0, ex(3'd6, NC, 2'b00, 1'b1, 16'd0));
        drive(1'b1, 1'b0, OP_ADD, 1'b0);
        cyc();
        cyc();
        chk("ill_sticky", o0, ex(3'd6, NC, 2'b00, 1'b1, 16'd0));

        // asynchronous reset in the middle of a STUR memory write
        do_reset();
        drive(1'b0, 1'b1, OP_ADD, 1'b0);
        cyc();
        drive(1'b0, 1'b0, OP_ADD, 1'b0);
        repeat (4) cyc();
        chk("pre_add_done", o0, ex(3'd0, NC, 2'b00, 1'b0, 16'd1));
        drive(1'b0, 1'b1, OP_STUR, 1'b0);
        cyc();
        drive(1'b0, 1'b0, OP_STUR, 1'b0);
        repeat (3) cyc();
        chk("pre_rst_mem", o0, ex(3'd4, MW | PW, 2'b00, 1'b0, 16'd1));
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_mem", o0, ex(3'd0, NC, 2'b00, 1'b0, 16'd0));
        cyc();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_sequencer.md
MULTICYCLE_CONTROL_SEQUENCER -- requirements
Module: multicycle_control_sequencer

Interface
REQ-001 Parameter INSTR_LIMIT, default 16'd0, meaning instruction-count halt threshold (0 = no limit).
REQ-002 Parameter COUNT_W, default 16, meaning width of instrCount.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clock.
REQ-004 clock  input  1  system clock.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 start  input  1  pulse in IDLE: enter continuous run.
REQ-007 step  input  1  pulse in IDLE: execute exactly one instruction.
REQ-008 opcode  input  11  instruction bits [31:21] from the IR; valid from DECODE onward.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 pcWrite, pcSrc, irWrite, regWrite, memRead, memWrite, aluSrc, memToReg, reg2Loc  output  1 each  datapath controls.
REQ-011 aluOp  output  2  00 add (address), 01 pass-B/compare (CBZ), 10 R-type funct.
REQ-012 state  output  3  current FSM state code.
REQ-013 busy  output  1  high in any state other than IDLE and HALT.
REQ-014 halted  output  1  high in HALT.
REQ-015 illegal  output  1  sticky; set on an undecodable opcode.
REQ-016 instrCount  output  COUNT_W  number of completed instructions.

Function
REQ-017 State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6; code 7 SHALL return to IDLE on the next edge.
REQ-018 Decode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx; any other opcode is illegal.
REQ-019 IDLE: start -> FETCH in run mode; step (without start) -> FETCH in step mode; start and step together -> run mode.
REQ-020 FETCH: irWrite=1 for exactly one cycle -> DECODE.
REQ-021 DECODE: the controller SHALL latch opcode internally; reg2Loc=1 for STUR and CBZ; illegal -> HALT with illegal set, else -> EXECUTE.
REQ-022 EXECUTE: R-type -> aluSrc=0, aluOp=10 -> WRITEBACK; LDUR/STUR -> aluSrc=1, aluOp=00 -> MEMORY; CBZ -> aluOp=01, pcWrite=1, pcSrc=zero sampled this cycle (completion); B -> pcWrite=1, pcSrc=1 (completion).
REQ-023 MEMORY: LDUR -> memRead=1 -> WRITEBACK; STUR -> memWrite=1, pcWrite=1, pcSrc=0 (completion).
REQ-024 WRITEBACK: regWrite=1, memToReg=1 for LDUR and 0 for R-type, pcWrite=1, pcSrc=0 (completion).
REQ-025 Latency from FETCH entry to completion: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles.
REQ-026 Completion SHALL increment instrCount by 1, wrapping modulo 2^COUNT_W.
REQ-027 After completion: if INSTR_LIMIT != 0 and the new count == INSTR_LIMIT -> HALT; else in step mode -> IDLE; else -> FETCH.
REQ-028 Every control output not asserted by a rule above SHALL be 0; pcWrite, regWrite, memRead, memWrite and irWrite SHALL each be high for at most one cycle per instruction.
REQ-029 start and step outside IDLE SHALL be ignored.
REQ-030 HALT SHALL be exited only by reset.

Reset
REQ-031 resetN low SHALL force, asynchronously, state=IDLE, step mode cleared, instrCount=0, illegal=0, and all control outputs, busy and halted to 0, including mid-instruction; a write strobe in progress SHALL drop immediately.
REQ-032 After resetN deasserts, the block SHALL remain in IDLE until a start or step pulse.

Verification
REQ-033 Reset, then a step pulse with opcode=ADD -> states 1,2,3,5,0; irWrite in cycle 1; regWrite and pcWrite only in cycle 4; instrCount=1.
REQ-034 Start with opcode=LDUR held -> memRead in cycle 4, regWrite=1 with memToReg=1 in cycle 5, then FETCH again; instrCount increments every 5 cycles.
REQ-035 Step with CBZ, zero=1 -> pcWrite=1 and pcSrc=1 in EXECUTE; repeat with zero=0 -> pcSrc=0; latency 3 cycles each.
REQ-036 With INSTR_LIMIT=3, start with opcode=STUR -> HALT after the 3rd memWrite; halted=1; instrCount=3; start is ignored afterwards.
REQ-037 Opcode=11111111111 -> HALT from DECODE; illegal=1; no regWrite, memWrite or pcWrite; instrCount unchanged.
REQ-038 Reset asserted during MEMORY of STUR -> memWrite drops without waiting for a clock edge; state=0; instrCount=0.
